// File: rtl/ct_spsram_1024x59_ctrl.sv
// Controller for a 1024x59 single-port SRAM: after reset or a flush it
// zero-fills the whole array, then arbitrates one write requester and one
// read requester onto the single SRAM port with 1-cycle read latency.
module ct_spsram_1024x59_ctrl #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        wr_req_vld,
  input  logic [9:0]  wr_req_addr,
  input  logic [58:0] wr_req_data,
  input  logic [58:0] wr_req_mask,
  output logic        wr_req_gnt,
  input  logic        rd_req_vld,
  input  logic [9:0]  rd_req_addr,
  output logic        rd_req_gnt,
  output logic        rd_data_vld,
  output logic [58:0] rd_data,
  input  logic        flush_req,
  output logic        init_done,
  output logic [9:0]  sram_a,
  output logic        sram_cen,
  output logic [58:0] sram_d,
  output logic        sram_gwen,
  output logic [58:0] sram_wen,
  input  logic [58:0] sram_q
);

  localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t      state_q;
  logic [9:0]  init_cnt_q;
  logic        last_gnt_q;    // 0 = write granted last, 1 = read granted last
  logic        rd_vld_q;
  logic        init_done_q;

  logic        in_init;
  logic        arb_en;

  // Arbitration: grants are combinational and suppressed during reset,
  // during the sweep and in the cycle a flush is accepted.
  always_comb begin
    in_init    = cpurst_b && (state_q == INIT);
    arb_en     = cpurst_b && (state_q == RUN) && !flush_req;
    wr_req_gnt = arb_en && wr_req_vld && (!rd_req_vld || last_gnt_q);
    rd_req_gnt = arb_en && rd_req_vld && (!wr_req_vld || !last_gnt_q);
  end

  // SRAM port mux: sweep write, granted write, granted read, or idle.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (in_init) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_q;
    end else if (wr_req_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~wr_req_mask;
      sram_a    = wr_req_addr;
      sram_d    = wr_req_data;
    end else if (rd_req_gnt) begin
      sram_cen  = 1'b0;
      sram_a    = rd_req_addr;
    end
  end

  // Status outputs are forced inactive for as long as reset is held.
  always_comb begin
    rd_data_vld = rd_vld_q && cpurst_b;
    rd_data     = rd_data_vld ? sram_q : '0;
    init_done   = init_done_q && cpurst_b;
  end

  // FSM, sweep counter, round-robin history and read-valid pipeline.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      last_gnt_q  <= 1'b1;
      rd_vld_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_req_gnt;
      if (wr_req_gnt) begin
        last_gnt_q <= 1'b0;
      end else if (rd_req_gnt) begin
        last_gnt_q <= 1'b1;
      end
      case (state_q)
        INIT: begin
          if (init_cnt_q == LAST_ADDR) begin
            init_cnt_q  <= '0;
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 10'd1;
          end
        end
        RUN: begin
          if (flush_req) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_spsram_1024x59_ctrl.sv
// Directed bench for ct_spsram_1024x59_ctrl with a behavioural 1024x59
// SRAM (bit-masked write, 1-cycle registered read).
module tb_ct_spsram_1024x59_ctrl;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst_b;
  logic        wr_req_vld;
  logic [9:0]  wr_req_addr;
  logic [58:0] wr_req_data;
  logic [58:0] wr_req_mask;
  logic        wr_req_gnt;
  logic        rd_req_vld;
  logic [9:0]  rd_req_addr;
  logic        rd_req_gnt;
  logic        rd_data_vld;
  logic [58:0] rd_data;
  logic        flush_req;
  logic        init_done;
  logic [9:0]  sram_a;
  logic        sram_cen;
  logic [58:0] sram_d;
  logic        sram_gwen;
  logic [58:0] sram_wen;
  logic [58:0] sram_q;

  int checks = 0;
  int errors = 0;

  localparam logic [58:0] D_5A  = 59'h5A5A5A5A5A5A5A5;
  localparam logic [58:0] D_ARB = 59'h0000000000000123;
  localparam logic [58:0] D_FL  = 59'h123456789ABCDEF;

  logic [58:0] mem [0:1023];

  always #5 forever_cpuclk = ~forever_cpuclk;

  ct_spsram_1024x59_ctrl #(.DEPTH(1024)) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .wr_req_vld     (wr_req_vld),
    .wr_req_addr    (wr_req_addr),
    .wr_req_data    (wr_req_data),
    .wr_req_mask    (wr_req_mask),
    .wr_req_gnt     (wr_req_gnt),
    .rd_req_vld     (rd_req_vld),
    .rd_req_addr    (rd_req_addr),
    .rd_req_gnt     (rd_req_gnt),
    .rd_data_vld    (rd_data_vld),
    .rd_data        (rd_data),
    .flush_req      (flush_req),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_d         (sram_d),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_q         (sram_q)
  );

  // SRAM model: WEN bit low = write that bit.
  always @(posedge forever_cpuclk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge forever_cpuclk);
    #1;
  endtask

  // One sweep cycle: status low, no grants, zero write at address i.
  task automatic chk_sweep(input int unsigned i);
    chk("sweep", {init_done, wr_req_gnt, rd_req_gnt, sram_cen, sram_gwen, sram_a,
                  (sram_d == 59'd0), (sram_wen == 59'd0)},
        {5'b00000, 10'(i), 2'b11});
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {sram_cen, sram_gwen, (sram_wen == {59{1'b1}}), sram_a, (sram_d == 59'd0)},
        {3'b111, 10'd0, 1'b1});
  endtask

  task automatic full_sweep();
    for (int unsigned i = 0; i < 1024; i++) begin
      chk_sweep(i);
      step();
    end
    chk("init_done_after_sweep", {63'd0, init_done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    sram_q      = '0;
    cpurst_b    = 1'b0;
    wr_req_vld  = 1'b1;
    wr_req_addr = 10'd3;
    wr_req_data = '1;
    wr_req_mask = '1;
    rd_req_vld  = 1'b1;
    rd_req_addr = 10'd4;
    flush_req   = 1'b0;
    repeat (3) step();

    // Reset state with both requesters asking.
    chk("rst_gnt", {62'd0, wr_req_gnt, rd_req_gnt}, 64'd0);
    chk("rst_status", {62'd0, init_done, rd_data_vld}, 64'd0);
    chk("rst_rd_data", {5'd0, rd_data}, 64'd0);
    chk_idle("rst_sram_idle");
    wr_req_vld = 1'b0;
    rd_req_vld = 1'b0;

    // Release: sweep writes 0..1023, RUN on the 1025th cycle.
    cpurst_b = 1'b1;
    #1;
    full_sweep();
    chk_idle("run_idle");
    chk("run_rd_data_zero", {5'd0, rd_data}, 64'd0);

    // Full write then read-back of the top address.
    wr_req_vld = 1'b1; wr_req_addr = 10'h3FF; wr_req_data = D_5A; wr_req_mask = '1;
    #1;
    chk("wr_gnt", {62'd0, wr_req_gnt, rd_req_gnt}, 64'b10);
    chk("wr_sram_ctl", {sram_cen, sram_gwen, (sram_wen == 59'd0), sram_a}, {3'b001, 10'h3FF});
    chk("wr_sram_d", {5'd0, sram_d}, {5'd0, D_5A});
    step();
    wr_req_vld = 1'b0; rd_req_vld = 1'b1; rd_req_addr = 10'h3FF;
    #1;
    chk("rd_gnt", {62'd0, wr_req_gnt, rd_req_gnt}, 64'b01);
    chk("rd_sram_ctl", {sram_cen, sram_gwen, (sram_wen == {59{1'b1}}), sram_a}, {3'b011, 10'h3FF});
    step();
    rd_req_vld = 1'b0;
    #1;
    chk("rd_vld_3ff", {63'd0, rd_data_vld}, 64'd1);
    chk("rd_data_3ff", {5'd0, rd_data}, {5'd0, D_5A});
    step();
    chk("rd_vld_one_cycle", {63'd0, rd_data_vld}, 64'd0);

    // Partial mask write over a zeroed entry, then immediate read.
    wr_req_vld = 1'b1; wr_req_addr = 10'd5; wr_req_data = '1; wr_req_mask = 59'h1;
    #1;
    chk("pm_wen", {5'd0, sram_wen}, {5'd0, ~59'h1});
    step();
    wr_req_vld = 1'b0; rd_req_vld = 1'b1; rd_req_addr = 10'd5;
    step();
    rd_req_vld = 1'b0;
    #1;
    chk("pm_readback", {4'd0, rd_data_vld, rd_data}, {4'd0, 1'b1, 59'h1});

    // Both requesters held: last grant was a read, so write wins first.
    wr_req_vld = 1'b1; wr_req_addr = 10'd10; wr_req_data = D_ARB; wr_req_mask = '1;
    rd_req_vld = 1'b1; rd_req_addr = 10'd20;
    #1;
    chk("arb_c1", {52'd0, wr_req_gnt, rd_req_gnt, sram_a}, {52'd0, 2'b10, 10'd10});
    step();
    chk("arb_c2", {52'd0, wr_req_gnt, rd_req_gnt, sram_a}, {52'd0, 2'b01, 10'd20});
    step();
    chk("arb_c3", {52'd0, wr_req_gnt, rd_req_gnt, sram_a}, {52'd0, 2'b10, 10'd10});
    chk("arb_c3_rd", {4'd0, rd_data_vld, rd_data}, {4'd0, 1'b1, 59'd0});
    step();
    chk("arb_c4", {52'd0, wr_req_gnt, rd_req_gnt, sram_a}, {52'd0, 2'b01, 10'd20});
    chk("arb_c4_rd", {63'd0, rd_data_vld}, 64'd0);
    step();

    // Lone read is granted even though read was granted last.
    wr_req_vld = 1'b0; rd_req_addr = 10'd10;
    #1;
    chk("lone_rd_gnt", {62'd0, wr_req_gnt, rd_req_gnt}, 64'b01);
    step();
    rd_req_vld = 1'b0;
    #1;
    chk("lone_rd_data", {4'd0, rd_data_vld, rd_data}, {4'd0, 1'b1, D_ARB});

    // Flush the cycle after a read grant: the read still returns.
    wr_req_vld = 1'b1; wr_req_addr = 10'd7; wr_req_data = D_FL;
    step();
    wr_req_vld = 1'b0; rd_req_vld = 1'b1; rd_req_addr = 10'd7;
    #1;
    chk("fl_rd_gnt", {63'd0, rd_req_gnt}, 64'd1);
    step();
    flush_req = 1'b1; wr_req_vld = 1'b1;
    #1;
    chk("fl_no_gnt", {62'd0, wr_req_gnt, rd_req_gnt}, 64'd0);
    chk_idle("fl_sram_idle");
    chk("fl_rd_return", {4'd0, rd_data_vld, rd_data}, {4'd0, 1'b1, D_FL});
    step();
    flush_req = 1'b0; wr_req_vld = 1'b0; rd_req_vld = 1'b0;
    #1;
    // Sweep after flush; a flush pulse mid-sweep must not restart it.
    for (int unsigned i = 0; i < 1024; i++) begin
      if (i == 100) flush_req = 1'b1;
      if (i == 101) flush_req = 1'b0;
      #1;
      chk_sweep(i);
      step();
    end
    chk("fl_init_done", {63'd0, init_done}, 64'd1);
    rd_req_vld = 1'b1; rd_req_addr = 10'd7;
    step();
    rd_req_addr = 10'h3FF;
    #1;
    chk("fl_rb_7", {4'd0, rd_data_vld, rd_data}, {4'd0, 1'b1, 59'd0});
    step();
    rd_req_vld = 1'b0;
    #1;
    chk("fl_rb_3ff", {4'd0, rd_data_vld, rd_data}, {4'd0, 1'b1, 59'd0});

    // Reset right after a read grant: no read data follows.
    rd_req_vld = 1'b1; rd_req_addr = 10'd10;
    #1;
    chk("mr_rd_gnt", {63'd0, rd_req_gnt}, 64'd1);
    step();
    rd_req_vld = 1'b0; cpurst_b = 1'b0;
    #1;
    chk("mr_no_vld", {4'd0, rd_data_vld, rd_data}, 64'd0);
    chk("mr_init_done", {63'd0, init_done}, 64'd0);
    step();
    chk("mr_no_vld2", {63'd0, rd_data_vld}, 64'd0);

    // Sweep aborted at address 500 restarts from 0.
    cpurst_b = 1'b1;
    #1;
    for (int unsigned i = 0; i <= 500; i++) begin
      chk_sweep(i);
      if (i != 500) step();
    end
    cpurst_b = 1'b0;
    #1;
    chk_idle("ab_rst_idle");
    step();
    step();
    cpurst_b = 1'b1;
    #1;
    full_sweep();
    chk_idle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
